// File: rtl/morse_decoder_pkg.sv
// Shared Morse definitions: default unit length, character code type and FSM states.
package morse_decoder_pkg;

  localparam int unsigned MORSE_UNIT_CYCLES_C = 600_000;

  typedef logic [5:0] char_t;

  localparam char_t CHAR_WORD_SPACE_C  = 6'd36;
  localparam char_t CHAR_LAST_SYMBOL_C = 6'd35;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// International Morse table: code -> element count and left-aligned pattern (1 = dash).
module morse_lut
  import morse_decoder_pkg::*;
(
  input  char_t      code,
  output logic [2:0] len,
  output logic [4:0] pattern,
  output logic       valid
);

  always_comb begin
    len     = '0;
    pattern = '0;
    valid   = 1'b1;
    case (code)
      6'd0:  {len, pattern} = {3'd2, 5'b01000}; // A .-
      6'd1:  {len, pattern} = {3'd4, 5'b10000}; // B -...
      6'd2:  {len, pattern} = {3'd4, 5'b10100}; // C -.-.
      6'd3:  {len, pattern} = {3'd3, 5'b10000}; // D -..
      6'd4:  {len, pattern} = {3'd1, 5'b00000}; // E .
      6'd5:  {len, pattern} = {3'd4, 5'b00100}; // F ..-.
      6'd6:  {len, pattern} = {3'd3, 5'b11000}; // G --.
      6'd7:  {len, pattern} = {3'd4, 5'b00000}; // H ....
      6'd8:  {len, pattern} = {3'd2, 5'b00000}; // I ..
      6'd9:  {len, pattern} = {3'd4, 5'b01110}; // J .---
      6'd10: {len, pattern} = {3'd3, 5'b10100}; // K -.-
      6'd11: {len, pattern} = {3'd4, 5'b01000}; // L .-..
      6'd12: {len, pattern} = {3'd2, 5'b11000}; // M --
      6'd13: {len, pattern} = {3'd2, 5'b10000}; // N -.
      6'd14: {len, pattern} = {3'd3, 5'b11100}; // O ---
      6'd15: {len, pattern} = {3'd4, 5'b01100}; // P .--.
      6'd16: {len, pattern} = {3'd4, 5'b11010}; // Q --.-
      6'd17: {len, pattern} = {3'd3, 5'b01000}; // R .-.
      6'd18: {len, pattern} = {3'd3, 5'b00000}; // S ...
      6'd19: {len, pattern} = {3'd1, 5'b10000}; // T -
      6'd20: {len, pattern} = {3'd3, 5'b00100}; // U ..-
      6'd21: {len, pattern} = {3'd4, 5'b00010}; // V ...-
      6'd22: {len, pattern} = {3'd3, 5'b01100}; // W .--
      6'd23: {len, pattern} = {3'd4, 5'b10010}; // X -..-
      6'd24: {len, pattern} = {3'd4, 5'b10110}; // Y -.--
      6'd25: {len, pattern} = {3'd4, 5'b11000}; // Z --..
      6'd26: {len, pattern} = {3'd5, 5'b11111}; // 0
      6'd27: {len, pattern} = {3'd5, 5'b01111}; // 1
      6'd28: {len, pattern} = {3'd5, 5'b00111}; // 2
      6'd29: {len, pattern} = {3'd5, 5'b00011}; // 3
      6'd30: {len, pattern} = {3'd5, 5'b00001}; // 4
      6'd31: {len, pattern} = {3'd5, 5'b00000}; // 5
      6'd32: {len, pattern} = {3'd5, 5'b10000}; // 6
      6'd33: {len, pattern} = {3'd5, 5'b11000}; // 7
      6'd34: {len, pattern} = {3'd5, 5'b11100}; // 8
      6'd35: {len, pattern} = {3'd5, 5'b11110}; // 9
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one character per valid/ready transfer and keys it out
// with standard unit timing (dot 1, dash 3, element space 1, trailing gap 3).
module morse_encoder
  import morse_decoder_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = MORSE_UNIT_CYCLES_C
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       char_valid_i,
  input  logic [5:0] char_i,
  output logic       char_ready_o,
  output logic       key_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned     UW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UW-1:0]   U_LAST     = UW'(UNIT_CYCLES - 1);
  localparam logic [2:0]      TRAIL_LAST = 3'd2;
  // Word-space gap starts part-way into its first unit so that the two
  // handshake IDLE cycles are absorbed and word silence totals 7 units.
  localparam logic [UW-1:0]   WS_START   = UW'((UNIT_CYCLES > 2) ? 2 : 0);
  localparam logic [2:0]      WS_LAST    = (UNIT_CYCLES > 2) ? 3'd3 : 3'd2;

  state_t        state, state_nxt;
  logic [UW-1:0] ucnt, ucnt_nxt;
  logic [2:0]    ecnt, ecnt_nxt;
  logic [2:0]    gap_last, gap_last_nxt;
  logic [2:0]    rem, rem_nxt;
  logic [4:0]    sr, sr_nxt;
  logic          key_q, key_nxt;
  logic          err_q, err_nxt;

  logic [2:0]    lut_len;
  logic [4:0]    lut_pattern;
  logic          lut_valid;
  logic          unit_end;
  logic          mark_done;

  morse_lut u_lut (
    .code    (char_i),
    .len     (lut_len),
    .pattern (lut_pattern),
    .valid   (lut_valid)
  );

  assign unit_end  = (ucnt == U_LAST);
  assign mark_done = unit_end && (sr[4] ? (ecnt == 3'd2) : (ecnt == 3'd0));

  always_comb begin
    state_nxt    = state;
    ucnt_nxt     = ucnt;
    ecnt_nxt     = ecnt;
    gap_last_nxt = gap_last;
    rem_nxt      = rem;
    sr_nxt       = sr;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        ucnt_nxt = '0;
        ecnt_nxt = '0;
        if (char_valid_i) begin
          if (lut_valid) begin
            state_nxt = MARK;
            sr_nxt    = lut_pattern;
            rem_nxt   = lut_len;
          end else if (char_i == CHAR_WORD_SPACE_C) begin
            state_nxt    = GAP;
            ucnt_nxt     = WS_START;
            gap_last_nxt = WS_LAST;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      MARK: begin
        ucnt_nxt = unit_end ? '0 : ucnt + UW'(1);
        if (mark_done) begin
          ecnt_nxt = '0;
          sr_nxt   = {sr[3:0], 1'b0};
          rem_nxt  = rem - 3'd1;
          if (rem == 3'd1) begin
            state_nxt    = GAP;
            gap_last_nxt = TRAIL_LAST;
          end else begin
            state_nxt = SPACE;
          end
        end else if (unit_end) begin
          ecnt_nxt = ecnt + 3'd1;
        end
      end

      SPACE: begin
        ucnt_nxt = unit_end ? '0 : ucnt + UW'(1);
        if (unit_end) state_nxt = MARK;
      end

      GAP: begin
        ucnt_nxt = unit_end ? '0 : ucnt + UW'(1);
        if (unit_end) begin
          if (ecnt == gap_last) begin
            state_nxt = IDLE;
            ecnt_nxt  = '0;
          end else begin
            ecnt_nxt = ecnt + 3'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    key_nxt = (state_nxt == MARK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      ucnt     <= '0;
      ecnt     <= '0;
      gap_last <= '0;
      rem      <= '0;
      sr       <= '0;
      key_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ucnt     <= ucnt_nxt;
      ecnt     <= ecnt_nxt;
      gap_last <= gap_last_nxt;
      rem      <= rem_nxt;
      sr       <= sr_nxt;
      key_q    <= key_nxt;
      err_q    <= err_nxt;
    end
  end

  assign char_ready_o = (state == IDLE);
  assign busy_o       = ~char_ready_o;
  assign key_o        = key_q;
  assign err_o        = err_q;

endmodule
